// File: rtl/uart_rx_8n1_pkg.sv
// Shared UART definitions: receiver state encoding and the default bit period,
// common to the 8N1 receiver and its matching transmitter.
package uart_rx_8n1_pkg;

    // 625 clocks per bit gives 19200 baud from a 12 MHz clock
    localparam int UART_CLKS_PER_BIT_DEFAULT = 625;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_8n1_sync2.sv
// Two-flop synchronizer for a single asynchronous input. Both flops reset
// high so an idle serial line is not mistaken for a start bit after reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Shift the asynchronous input through two flops to settle metastability
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver. Finds the falling edge of the start bit, re-checks it at
// mid-bit to reject glitches, then samples each data bit and the stop bit at
// the centre of its bit period. Good frames update rxbyte with a one-cycle
// rxdone pulse; a low stop bit gives a one-cycle rxerr pulse and the receiver
// waits for the line to return high before hunting for the next start bit.
module uart_rx_8n1
    import uart_rx_8n1_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxdone,
    output logic       rxerr,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    // Last count of a full bit period, and of half a bit (start-bit centre)
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic           rx_s;
    uart_rx_state_e state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shift_r;
    logic [7:0]     rxbyte_r;
    logic           rxdone_r;
    logic           rxerr_r;
    logic           busy_r;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Receive state machine with registered pulse, data and busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            rxbyte_r  <= 8'h00;
            rxdone_r  <= 1'b0;
            rxerr_r   <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            // Pulses are high for one cycle only unless re-asserted below
            rxdone_r <= 1'b0;
            rxerr_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    if (rx_s == 1'b0) begin
                        state_r <= ST_START;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_HALF) begin
                        cnt_r <= '0;
                        // Still low at mid-bit: genuine start bit
                        if (rx_s == 1'b0) begin
                            state_r <= ST_DATA;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_FULL) begin
                        cnt_r     <= '0;
                        shift_r   <= {rx_s, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_STOP;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CNT_FULL) begin
                        cnt_r <= '0;
                        if (rx_s == 1'b1) begin
                            rxbyte_r <= shift_r;
                            rxdone_r <= 1'b1;
                            state_r  <= ST_IDLE;
                            busy_r   <= 1'b0;
                        end else begin
                            rxerr_r <= 1'b1;
                            state_r <= ST_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    // Hold off until the line is released so a long low
                    // level is never read as a new start bit
                    cnt_r <= '0;
                    if (rx_s == 1'b1) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_BREAK;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign rxbyte = rxbyte_r;
    assign rxdone = rxdone_r;
    assign rxerr  = rxerr_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 at 16 clocks per bit. Frames are driven
// by a serial transmitter model; expected bytes go into a scoreboard queue as
// each good frame is driven and are popped when rxdone fires.
module tb_uart_rx_8n1;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rxbyte;
    logic       rxdone;
    logic       rxerr;
    logic       busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int done_cnt     = 0;
    int err_cnt      = 0;
    int last_done_cyc = 0;
    int prev_done_cyc = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;
    logic [7:0] exp_b;
    logic [7:0] exp_q[$];

    uart_rx_8n1 #(.CLKS_PER_BIT(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rxbyte (rxbyte),
        .rxdone (rxdone),
        .rxerr  (rxerr),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: scoreboard compare on rxdone, pulse-shape checks
    always @(negedge clk) begin
        if (rxdone === 1'b1) begin
            done_cnt++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_rxdone: rxbyte %02h, no frame expected", rxbyte);
            end else begin
                exp_b = exp_q.pop_front();
                if (rxbyte !== exp_b) begin
                    tests_failed++;
                    $display("FAIL rxbyte_scoreboard: got %02h, expected %02h", rxbyte, exp_b);
                end
            end
            tests_run++;
            if (rxerr !== 1'b0 || prev_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL rxdone_pulse_shape: rxerr=%b prev_rxdone=%b, expected 0 0", rxerr, prev_done);
            end
        end
        if (rxerr === 1'b1) begin
            err_cnt++;
            tests_run++;
            if (prev_err !== 1'b0) begin
                tests_failed++;
                $display("FAIL rxerr_pulse_shape: rxerr high two cycles running");
            end
        end
        prev_done = rxdone;
        prev_err  = rxerr;
    end

    // Serial transmitter model: start bit, 8 data bits LSB first, stop bit
    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (N) @(negedge clk);
        end
        rx = stop_v;
        repeat (N) @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({rxbyte, rxdone, rxerr, busy} !== 11'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: rxbyte=%02h rxdone=%b rxerr=%b busy=%b, expected 00 0 0 0",
                     rxbyte, rxdone, rxerr, busy);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_single();
        int d0 = done_cnt;
        int e0 = err_cnt;
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        chk("single_done_count", done_cnt - d0, 1);
        chk("single_err_count", err_cnt - e0, 0);
        tests_run++;
        if (rxbyte !== 8'h55) begin
            tests_failed++;
            $display("FAIL single_rxbyte: got %02h, expected 55", rxbyte);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("b2b_spacing", last_done_cyc - prev_done_cyc, 10 * N);
        tests_run++;
        if (rxbyte !== 8'hFF) begin
            tests_failed++;
            $display("FAIL b2b_rxbyte: got %02h, expected ff", rxbyte);
        end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [7:0] b0 = rxbyte;
        logic idle_seen = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                idle_seen = 1'b1;
                break;
            end
        end
        chk("glitch_busy_released", int'(idle_seen), 1);
        repeat (2 * N) @(negedge clk);
        chk("glitch_no_done", done_cnt - d0, 0);
        chk("glitch_no_err", err_cnt - e0, 0);
        tests_run++;
        if (rxbyte !== b0) begin
            tests_failed++;
            $display("FAIL glitch_rxbyte: got %02h, expected %02h", rxbyte, b0);
        end
    endtask

    task automatic test_framing();
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [7:0] b0 = rxbyte;
        send_byte(8'hA5, 1'b0);
        repeat (40) @(negedge clk);
        chk("frame_err_count", err_cnt - e0, 1);
        chk("frame_no_done", done_cnt - d0, 0);
        chk("break_busy_high", int'(busy), 1);
        tests_run++;
        if (rxbyte !== b0) begin
            tests_failed++;
            $display("FAIL frame_rxbyte: got %02h, expected %02h", rxbyte, b0);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_busy_released", int'(busy), 0);
        repeat (N) @(negedge clk);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        tests_run++;
        if (rxbyte !== 8'h3C) begin
            tests_failed++;
            $display("FAIL after_break_rxbyte: got %02h, expected 3c", rxbyte);
        end
    endtask

    task automatic test_reset_midframe();
        int d0 = done_cnt;
        int e0 = err_cnt;
        logic [7:0] b = 8'h81;
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (N) @(negedge clk);
        end
        rx = b[4];
        repeat (N / 2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({rxbyte, rxdone, rxerr, busy} !== 11'h000) begin
            tests_failed++;
            $display("FAIL midframe_reset_outputs: rxbyte=%02h rxdone=%b rxerr=%b busy=%b, expected 00 0 0 0",
                     rxbyte, rxdone, rxerr, busy);
        end
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3 * N) @(negedge clk);
        chk("midframe_no_done", done_cnt - d0, 0);
        chk("midframe_no_err", err_cnt - e0, 0);
        chk("midframe_busy", int'(busy), 0);
        exp_q.push_back(8'h42);
        send_byte(8'h42, 1'b1);
        rx = 1'b1;
        repeat (2 * N) @(negedge clk);
        tests_run++;
        if (rxbyte !== 8'h42) begin
            tests_failed++;
            $display("FAIL midframe_next_rxbyte: got %02h, expected 42", rxbyte);
        end
    endtask

    task automatic test_loopback();
        int d0 = done_cnt;
        int e0 = err_cnt;
        for (int c = 8'h41; c <= 8'h5A; c++) begin
            exp_q.push_back(8'(c));
            send_byte(8'(c), 1'b1);
            rx = 1'b1;
            repeat (N) @(negedge clk);
        end
        repeat (2 * N) @(negedge clk);
        chk("loopback_done_count", done_cnt - d0, 26);
        chk("loopback_err_count", err_cnt - e0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
